multi_lane_dru: RTL and testbench

Parametrised, multi-lane successor of the 4x-oversampling data recovery unit. Each lane takes an 8-sample window per clock (2 nominal bits at 4x), tracks the eye phase with a 4-state machine, and extracts 1–3 bits per cycle. A per-lane gearbox packs the recovered bits into fixed OUT_W-bit words with a valid strobe. The block adds per-lane bitslip word alignment and a phase-stability indicator. It sits between the ISERDES sample front-end and the word-level deserializer consumers.

---
 rtl/multi_lane_dru_if.sv | 23 ++
 rtl/multi_lane_dru.sv | 182 ++++++++++++++++++
 tb/tb_multi_lane_dru.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_lane_dru_if.sv
// Sample-window / recovered-word bundle between the sampler front-end,
// the multi-lane DRU and the word consumers.
interface multi_lane_dru_if #(
    parameter int LANES = 1,
    parameter int OUT_W = 10
);
    logic [8*LANES-1:0]     sample_window;
    logic [LANES-1:0]       bitslip;
    logic [OUT_W*LANES-1:0] out_data;
    logic [LANES-1:0]       out_valid;
    logic [2*LANES-1:0]     phase;
    logic [LANES-1:0]       phase_stable;

    modport master (
        output sample_window, bitslip,
        input  out_data, out_valid, phase, phase_stable
    );

    modport slave (
        input  sample_window, bitslip,
        output out_data, out_valid, phase, phase_stable
    );
endinterface

// File: rtl/multi_lane_dru.sv
// Multi-lane 4x-oversampling data recovery unit: per-lane eye-phase tracking,
// 1-3 bit extraction, bitslip, OUT_W-bit gearbox and phase-stability flag.
module multi_lane_dru #(
    parameter int LANES       = 1,
    parameter int OUT_W       = 10,
    parameter int LOCK_CYCLES = 64
) (
    input  logic            clk,
    input  logic            areset,
    multi_lane_dru_if.slave bus
);
    localparam int ACC_W  = OUT_W + 2;
    localparam int CNT_W  = $clog2(ACC_W + 1);
    localparam int STAB_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0]  OUT_W_C = CNT_W'(OUT_W);
    localparam logic [STAB_W-1:0] LOCK_C  = STAB_W'(LOCK_CYCLES);

    typedef enum logic [1:0] {
        P0 = 2'b00,
        P1 = 2'b01,
        P3 = 2'b11,
        P2 = 2'b10
    } phase_t;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0]        w_win;
        logic [7:0]        r_sw;
        logic              r_p7;
        logic              r_sw_vld;
        logic [3:0]        w_edge;
        phase_t            r_phase;
        phase_t            r_sp;
        logic [2:0]        w_bits;
        logic [1:0]        w_nbits;
        logic [2:0]        r_bits;
        logic [1:0]        r_nbits;
        logic              r_bits_vld;
        logic [STAB_W-1:0] r_stab;
        logic [1:0]        w_nin;
        logic [2:0]        w_in;
        logic              w_emit;
        logic [OUT_W-1:0]  w_word;
        logic [CNT_W-1:0]  w_rem_cnt;
        logic [ACC_W-1:0]  w_rem;
        logic [ACC_W-1:0]  w_acc_nxt;
        logic [CNT_W-1:0]  w_cnt_nxt;
        logic [ACC_W-1:0]  r_acc;
        logic [CNT_W-1:0]  r_cnt;
        logic [OUT_W-1:0]  r_word;
        logic              r_word_vld;

        assign w_win = bus.sample_window[8*k +: 8];

        // r_sw_vld keeps the all-zero reset window out of the FSM and the gearbox.
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge clk) begin
            if (areset) begin
                r_sw     <= '0;
                r_p7     <= 1'b0;
                r_sw_vld <= 1'b0;
            end else begin
                r_sw     <= w_win;
                r_p7     <= r_sw[7];
                r_sw_vld <= 1'b1;
            end
        end

        // Odd samples are inverted, so equal raw samples mean a data transition.
        assign w_edge[0] = (r_sw[0] == r_sw[1]) | (r_sw[4] == r_sw[5]);
        assign w_edge[1] = (r_sw[1] == r_sw[2]) | (r_sw[5] == r_sw[6]);
        assign w_edge[2] = (r_sw[2] == r_sw[3]) | (r_sw[6] == r_sw[7]);
        assign w_edge[3] = (r_sw[3] == r_sw[4]) | (r_p7 == r_sw[0]);

        // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latch).
        always_comb begin
            w_bits  = {1'b0, ~r_sw[1], ~r_sw[5]};
            w_nbits = 2'd2;
            case (r_phase)
                P0: begin
                    if (r_sp == P2) begin
                        w_bits  = {r_sw[0], r_sw[4], ~r_sw[7]};
                        w_nbits = 2'd3;
                    end else begin
                        w_bits = {1'b0, r_sw[0], r_sw[4]};
                    end
                end
                P3: w_bits = {1'b0, r_sw[2], r_sw[6]};
                P2: begin
                    if (r_sp == P0) begin
                        w_bits  = {2'b00, ~r_sw[3]};
                        w_nbits = 2'd1;
                    end else begin
                        w_bits = {1'b0, ~r_sw[3], ~r_sw[7]};
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk) begin
            if (areset) begin
                r_phase    <= P1;
                r_sp       <= P1;
                r_bits     <= '0;
                r_nbits    <= '0;
                r_bits_vld <= 1'b0;
                r_stab     <= '0;
            end else begin
                r_bits_vld <= r_sw_vld;
                if (r_sw_vld) begin
                    r_sp    <= r_phase;
                    r_bits  <= w_bits;
                    r_nbits <= w_nbits;
                    case (r_phase)
                        P0: begin
                            if (w_edge[3])      r_phase <= P1;
                            else if (w_edge[0]) r_phase <= P2;
                        end
                        P1: begin
                            if (w_edge[0])      r_phase <= P3;
                            else if (w_edge[1]) r_phase <= P0;
                        end
                        P2: begin
                            if (w_edge[2])      r_phase <= P0;
                            else if (w_edge[3]) r_phase <= P3;
                        end
                        P3: begin
                            if (w_edge[1])      r_phase <= P2;
                            else if (w_edge[2]) r_phase <= P1;
                        end
                        default: r_phase <= P1;
                    endcase
                    if (r_phase != r_sp) begin
                        r_stab <= '0;
                    end else if (r_stab != LOCK_C) begin
                        r_stab <= r_stab + 1'b1;
                    end
                end
            end
        end

        // Accumulator is right-aligned: earliest held bit sits at position r_cnt-1.
        always_comb begin
            w_nin = 2'd0;
            w_in  = 3'd0;
            if (r_bits_vld) begin
                w_nin = r_nbits - {1'b0, bus.bitslip[k]};
                w_in  = r_bits & ((3'd1 << w_nin) - 3'd1);
            end
            w_emit    = (r_cnt >= OUT_W_C);
            w_word    = r_word;
            w_rem_cnt = r_cnt;
            w_rem     = r_acc;
            if (w_emit) begin
                w_word    = OUT_W'(r_acc >> (r_cnt - OUT_W_C));
                w_rem_cnt = r_cnt - OUT_W_C;
                w_rem     = r_acc & ((ACC_W'(1) << w_rem_cnt) - ACC_W'(1));
            end
            w_acc_nxt = (w_rem << w_nin) | ACC_W'(w_in);
            w_cnt_nxt = w_rem_cnt + CNT_W'(w_nin);
        end

        always_ff @(posedge clk) begin
            if (areset) begin
                r_acc      <= '0;
                r_cnt      <= '0;
                r_word     <= '0;
                r_word_vld <= 1'b0;
            end else begin
                r_acc      <= w_acc_nxt;
                r_cnt      <= w_cnt_nxt;
                r_word     <= w_word;
                r_word_vld <= w_emit;
            end
        end

        assign bus.out_data[OUT_W*k +: OUT_W] = r_word;
        assign bus.out_valid[k]               = r_word_vld;
        assign bus.phase[2*k +: 2]            = r_phase;
        assign bus.phase_stable[k]            = (r_stab == LOCK_C);
    end
endmodule

// File: tb/tb_multi_lane_dru.sv
// Self-checking bench for multi_lane_dru: directed tables and sequences plus
// randomized windows checked against a bit-queue reference model.
module tb_multi_lane_dru;
    localparam int LANES = 2;
    localparam int OUT_W = 10;
    localparam int LOCK  = 8;
    localparam int WW    = 8 * LANES;

    logic clk;
    logic areset;
    int   tests = 0;
    int   fails = 0;

    multi_lane_dru_if #(.LANES(LANES), .OUT_W(OUT_W)) bus ();

    multi_lane_dru #(.LANES(LANES), .OUT_W(OUT_W), .LOCK_CYCLES(LOCK)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: phases as gray codes, bits as plain queues of true samples.
    typedef struct packed {
        logic [1:0] from;
        logic [1:0] eidx;
        logic [1:0] to;
    } rule_t;

    typedef struct packed {
        logic [31:0] n;
        logic [2:0]  b;
    } grp_t;

    rule_t            rules [8];
    grp_t             m_pipe [LANES][$];
    bit               m_bits [LANES][$];
    logic [1:0]       m_phase [LANES];
    logic [1:0]       m_sp [LANES];
    bit               m_t7 [LANES];
    int               m_stab [LANES];
    bit               have_pend [LANES];
    logic [1:0]       pend_phase [LANES];
    int               pend_stab [LANES];
    logic [1:0]       exp_phase [LANES];
    int               exp_stab [LANES];
    bit               exp_valid [LANES];
    logic [OUT_W-1:0] exp_word [LANES];

    function automatic int offset_of(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < LANES; k++) begin
            m_pipe[k].delete();
            m_bits[k].delete();
            m_phase[k]   = 2'b01;
            m_sp[k]      = 2'b01;
            m_t7[k]      = 1'b1;
            m_stab[k]    = 0;
            have_pend[k] = 1'b0;
            exp_phase[k] = 2'b01;
            exp_stab[k]  = 0;
            exp_valid[k] = 1'b0;
            exp_word[k]  = '0;
        end
    endtask

    task automatic model_edge(input logic [WW-1:0] w, input logic [LANES-1:0] bs, input logic rst);
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < LANES; k++) begin
                logic [7:0]       sw;
                logic [7:0]       t;
                logic [3:0]       e;
                logic [1:0]       s;
                logic [1:0]       sp;
                logic [1:0]       nxt;
                logic [OUT_W-1:0] word;
                grp_t             g;
                int               off;
                sw = w[8*k +: 8];
                t  = sw ^ 8'hAA;
                if (have_pend[k]) begin
                    exp_phase[k] = pend_phase[k];
                    exp_stab[k]  = pend_stab[k];
                end
                exp_valid[k] = 1'b0;
                if (m_bits[k].size() >= OUT_W) begin
                    word = '0;
                    for (int i = 0; i < OUT_W; i++) word = (word << 1) | OUT_W'(m_bits[k].pop_front());
                    exp_valid[k] = 1'b1;
                    exp_word[k]  = word;
                end
                if (m_pipe[k].size() == 2) begin
                    g = m_pipe[k].pop_front();
                    for (int i = (bs[k] ? 1 : 0); i < int'(g.n); i++) m_bits[k].push_back(g.b[i]);
                end
                e[0] = (t[0] != t[1]) || (t[4] != t[5]);
                e[1] = (t[1] != t[2]) || (t[5] != t[6]);
                e[2] = (t[2] != t[3]) || (t[6] != t[7]);
                e[3] = (t[3] != t[4]) || (m_t7[k] != t[0]);
                s   = m_phase[k];
                sp  = m_sp[k];
                off = offset_of(s);
                g.b = '0;
                g.b[0] = t[off];
                g.b[1] = t[off + 4];
                g.n = 2;
                if (s == 2'b00 && sp == 2'b10) begin
                    g.b[2] = t[7];
                    g.n = 3;
                end
                if (s == 2'b10 && sp == 2'b00) g.n = 1;
                nxt = s;
                for (int r = 0; r < 8; r++) begin
                    if (rules[r].from == s && e[rules[r].eidx]) begin
                        nxt = rules[r].to;
                        break;
                    end
                end
                m_stab[k]     = (s != sp) ? 0 : ((m_stab[k] < LOCK) ? m_stab[k] + 1 : LOCK);
                m_sp[k]       = s;
                m_phase[k]    = nxt;
                m_t7[k]       = t[7];
                pend_phase[k] = nxt;
                pend_stab[k]  = m_stab[k];
                have_pend[k]  = 1'b1;
                m_pipe[k].push_back(g);
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < LANES; k++) begin
            check($sformatf("lane%0d out_valid", k), 32'(bus.out_valid[k]), 32'(exp_valid[k]));
            check($sformatf("lane%0d out_data", k), 32'(bus.out_data[OUT_W*k +: OUT_W]), 32'(exp_word[k]));
            check($sformatf("lane%0d phase", k), 32'(bus.phase[2*k +: 2]), 32'(exp_phase[k]));
            check($sformatf("lane%0d phase_stable", k), 32'(bus.phase_stable[k]), 32'(exp_stab[k] == LOCK));
        end
    endtask

    task automatic step(input logic [WW-1:0] w, input logic [LANES-1:0] bs, input logic rst);
        bus.sample_window = w;
        bus.bitslip       = bs;
        areset            = rst;
        @(posedge clk);
        model_edge(w, bs, rst);
        #1;
        compare_all();
    endtask

    typedef struct {
        logic [7:0] w0;
        logic [7:0] w1;
        logic [1:0] p0;
        logic [1:0] p1;
    } vec_t;

    vec_t vecs [4];
    logic [OUT_W-1:0] last0;
    logic [OUT_W-1:0] last1;

    initial begin
        rules[0] = '{2'b00, 2'd3, 2'b01};
        rules[1] = '{2'b00, 2'd0, 2'b10};
        rules[2] = '{2'b01, 2'd0, 2'b11};
        rules[3] = '{2'b01, 2'd1, 2'b00};
        rules[4] = '{2'b10, 2'd2, 2'b00};
        rules[5] = '{2'b10, 2'd3, 2'b11};
        rules[6] = '{2'b11, 2'd1, 2'b10};
        rules[7] = '{2'b11, 2'd2, 2'b01};
        vecs[0] = '{8'hA5, 8'hB4, 2'b01, 2'b11};
        vecs[1] = '{8'h21, 8'hA5, 2'b00, 2'b01};
        vecs[2] = '{8'h00, 8'h21, 2'b11, 2'b00};
        vecs[3] = '{8'hFF, 8'h5A, 2'b11, 2'b01};
        model_reset();
        areset = 1'b1;
        bus.sample_window = '0;
        bus.bitslip = '0;

        // Reset held with random windows.
        for (int i = 0; i < 3; i++) begin
            step(WW'($urandom), LANES'($urandom), 1'b1);
            check("reset out_valid", 32'(bus.out_valid), 32'h0);
            check("reset out_data", 32'(bus.out_data), 32'h0);
            check("reset phase", 32'(bus.phase), 32'h5);
            check("reset phase_stable", 32'(bus.phase_stable), 32'h0);
        end

        // First-window phase decisions from reset.
        for (int v = 0; v < 4; v++) begin
            step('0, '0, 1'b1);
            step({vecs[v].w1, vecs[v].w0}, '0, 1'b0);
            step(16'hA5A5, '0, 1'b0);
            check($sformatf("table%0d lane0 phase", v), 32'(bus.phase[1:0]), 32'(vecs[v].p0));
            check($sformatf("table%0d lane1 phase", v), 32'(bus.phase[3:2]), 32'(vecs[v].p1));
        end

        // Aligned 0xA5 stream, then a single bitslip on lane 0.
        step('0, '0, 1'b1);
        for (int e = 1; e <= 40; e++) begin
            step(16'hA5A5, '0, 1'b0);
            if (e == 7) check("stream no early valid", 32'(bus.out_valid), 32'h0);
            if (e == 8) begin
                check("stream first valid", 32'(bus.out_valid), 32'h3);
                check("stream lane0 word", 32'(bus.out_data[9:0]), 32'h2AA);
                check("stream lane1 word", 32'(bus.out_data[19:10]), 32'h2AA);
            end
            if (e == LOCK) check("stable not yet", 32'(bus.phase_stable), 32'h0);
            if (e == LOCK + 1) check("stable asserted", 32'(bus.phase_stable), 32'h3);
        end
        step(16'hA5A5, 2'b01, 1'b0);
        last0 = '0;
        last1 = '0;
        for (int e = 0; e < 30; e++) begin
            step(16'hA5A5, '0, 1'b0);
            if (bus.out_valid[0]) last0 = bus.out_data[9:0];
            if (bus.out_valid[1]) last1 = bus.out_data[19:10];
        end
        check("bitslip lane0 word", 32'(last0), 32'h155);
        check("bitslip lane1 word", 32'(last1), 32'h2AA);

        // Phase move on lane 0 only.
        step('0, '0, 1'b1);
        for (int e = 0; e < LOCK + 4; e++) step(16'hA5A5, '0, 1'b0);
        step(16'hA5B4, '0, 1'b0);
        step(16'hA5A5, '0, 1'b0);
        check("move lane0 phase", 32'(bus.phase[1:0]), 32'h3);
        check("move lane0 still stable", 32'(bus.phase_stable[0]), 32'h1);
        check("move lane1 phase", 32'(bus.phase[3:2]), 32'h1);
        step(16'hA5A5, '0, 1'b0);
        check("move lane0 stable drop", 32'(bus.phase_stable[0]), 32'h0);
        check("move lane1 stable", 32'(bus.phase_stable[1]), 32'h1);
        for (int e = 0; e < LOCK + 2; e++) step(16'hA5A5, '0, 1'b0);
        check("move lane0 relock", 32'(bus.phase_stable[0]), 32'h1);

        // P0<->P2 wraps (3-bit and 1-bit cycles), with a run of bitslips.
        step('0, '0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            logic [7:0] w0;
            w0 = (i == 0) ? 8'h21 : ((i % 2 == 1) ? 8'h13 : 8'h00);
            step({8'hA5, w0}, {1'b0, (i >= 10 && i < 16)}, 1'b0);
            if (i >= 1) check("wrap lane0 phase", 32'(bus.phase[1:0]), ((i + 1) % 2 == 1) ? 32'h2 : 32'h0);
        end

        // Reset with 7 of 10 bits held on both lanes.
        step('0, '0, 1'b1);
        for (int e = 1; e <= 6; e++) step(16'hA5A5, (e == 3) ? 2'b11 : 2'b00, 1'b0);
        for (int e = 0; e < 2; e++) begin
            step(16'hA5A5, '0, 1'b1);
            check("midword reset no valid", 32'(bus.out_valid), 32'h0);
        end
        for (int e = 1; e <= 10; e++) begin
            step(16'hA5A5, '0, 1'b0);
            check("post-reset valid timing", 32'(bus.out_valid), (e == 8) ? 32'h3 : 32'h0);
            if (e == 8) check("post-reset word", 32'(bus.out_data), {12'h0, 10'h2AA, 10'h2AA});
        end

        // Randomized windows, bitslips and occasional resets.
        step('0, '0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            logic [LANES-1:0] bs;
            bs[0] = ($urandom_range(7) == 0);
            bs[1] = ($urandom_range(7) == 0);
            step(WW'($urandom), bs, ($urandom_range(499) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
